// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state type and default sizing for the multiplier handshake controller.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, HOLD} state_t;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_TIMEOUT = 24;
endpackage

// File: rtl/mult_watchdog.sv
// mult_watchdog: BUSY-cycle counter that flags the LIMIT-th enabled cycle after a load.
module mult_watchdog
  import mult_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else if (i_load) r_cnt <= '0;
    else if (i_en && !o_expire) r_cnt <= r_cnt + 1'b1;
  assign o_expire = i_en && (r_cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/mult_handshake_ctrl.sv
// mult_handshake_ctrl: valid/ready wrapper around a start/done multiplier core.
// Define MULT_TIMEOUT_EN to abort a stalled core after TIMEOUT BUSY cycles (dst_err=1).
module mult_handshake_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               src_valid,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic               src_ready,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_ready,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               dst_valid,
  output logic [2*WIDTH-1:0] dst_product,
  input  logic               dst_ready,
  output logic               dst_err
);
  state_t             r_state;
  logic               r_src_ready;
  logic               r_start;
  logic               r_dst_valid;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic               w_expire;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
`ifdef MULT_TIMEOUT_EN
  logic r_err;
  mult_watchdog #(.LIMIT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .i_load  (r_state == LAUNCH),
    .i_en    (r_state == BUSY),
    .o_expire(w_expire)
  );
  // A done pulse coinciding with expiry is a normal completion.
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_err <= 1'b0;
    else if (r_state == BUSY) r_err <= w_expire && !mul_ready;
    else if (r_state == HOLD && dst_ready) r_err <= 1'b0;
  assign dst_err = r_err;
`else
  assign w_expire = 1'b0;
  assign dst_err  = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= IDLE;
      r_src_ready <= 1'b1;
      r_start     <= 1'b0;
      r_dst_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_prod      <= '0;
    end else begin
      case (r_state)
        IDLE: if (src_valid) begin
          r_a         <= src_a;
          r_b         <= src_b;
          r_start     <= 1'b1;
          r_src_ready <= 1'b0;
          r_state     <= LAUNCH;
        end
        LAUNCH: begin
          r_start <= 1'b0;
          r_state <= BUSY;
        end
        BUSY: if (mul_ready || w_expire) begin
          r_prod      <= mul_ready ? mul_product : '0;
          r_dst_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: if (dst_ready) begin
          r_dst_valid <= 1'b0;
          r_src_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign src_ready   = r_src_ready;
  assign mul_start   = r_start;
  assign mul_a       = r_a;
  assign mul_b       = r_b;
  assign dst_valid   = r_dst_valid;
  assign dst_product = r_prod;
endmodule

// File: tb/tb_mult_handshake_ctrl.sv
// tb_mult_handshake_ctrl: scoreboard bench with a 17-cycle core stub; timeout cases need MULT_TIMEOUT_EN.
module tb_mult_handshake_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        src_valid, src_ready, mul_start, mul_ready, dst_valid, dst_ready, dst_err;
  logic [15:0] src_a, src_b, mul_a, mul_b;
  logic [31:0] mul_product, dst_product;

  mult_handshake_ctrl dut (
    .clk(clk), .rst(rst), .src_valid(src_valid), .src_a(src_a), .src_b(src_b),
    .src_ready(src_ready), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product), .dst_valid(dst_valid),
    .dst_product(dst_product), .dst_ready(dst_ready), .dst_err(dst_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] p;
    logic        e;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int failures = 0;
  int results = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the edge where dst_valid && dst_ready.
  initial forever begin
    @(negedge clk);
    if (rst && dst_valid && dst_ready) begin
      results++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=0x%0h required=none", dst_product);
      end else begin
        mon_e = sb.pop_front();
        chk("result_product", {32'h0, dst_product}, {32'h0, mon_e.p});
        chk("result_err", {63'h0, dst_err}, {63'h0, mon_e.e});
      end
    end
  end

  // Core stub: answers stub_delay cycles after mul_start with the signed product.
  int          stub_delay = 17;
  bit          stub_on = 1'b1;
  int          stub_cnt = 0;
  logic [31:0] stub_p;
  initial begin
    mul_ready = 1'b0;
    mul_product = '0;
    forever begin
      @(posedge clk);
      #1;
      mul_ready = 1'b0;
      if (mul_start && stub_on) begin
        stub_cnt = stub_delay;
        stub_p = $signed({{16{mul_a[15]}}, mul_a}) * $signed({{16{mul_b[15]}}, mul_b});
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          mul_ready = 1'b1;
          mul_product = stub_p;
        end
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!src_ready && t < 200) begin
      cyc(1);
      t++;
    end
  endtask

  task automatic send(logic [15:0] a, logic [15:0] b, logic [31:0] p, logic e, bit push);
    wait_ready();
    if (!src_ready) begin
      chk("src_ready_wait", {63'h0, src_ready}, 64'h1);
      return;
    end
    if (push) sb.push_back(exp_t'{p: p, e: e});
    src_valid = 1'b1;
    src_a = a;
    src_b = b;
    cyc(1);
    src_valid = 1'b0;
    chk("mul_start_next_cycle", {63'h0, mul_start}, 64'h1);
    chk("src_ready_low_launch", {63'h0, src_ready}, 64'h0);
    chk("mul_a_captured", {48'h0, mul_a}, {48'h0, a});
    chk("mul_b_captured", {48'h0, mul_b}, {48'h0, b});
    cyc(1);
    chk("mul_start_one_cycle", {63'h0, mul_start}, 64'h0);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      cyc(1);
      t++;
    end
    chk("drain_queue_empty", 64'(sb.size()), 64'h0);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int t;
    int bad;
    int r0;
    rst = 1'b1;
    src_valid = 1'b0;
    src_a = '0;
    src_b = '0;
    dst_ready = 1'b0;
    #1 rst = 1'b0;
    cyc(3);
    chk("rst_mul_start", {63'h0, mul_start}, 64'h0);
    chk("rst_dst_valid", {63'h0, dst_valid}, 64'h0);
    chk("rst_dst_err", {63'h0, dst_err}, 64'h0);
    chk("rst_mul_a", {48'h0, mul_a}, 64'h0);
    chk("rst_mul_b", {48'h0, mul_b}, 64'h0);
    chk("rst_dst_product", {32'h0, dst_product}, 64'h0);
    rst = 1'b1;
    cyc(1);
    chk("rst_src_ready", {63'h0, src_ready}, 64'h1);

    dst_ready = 1'b1;
    send(16'd3, 16'd5, 32'h0000000F, 1'b0, 1'b1);
    drain();
    send(16'hFFF9, 16'h0009, 32'hFFFFFFC1, 1'b0, 1'b1);
    drain();

    dst_ready = 1'b0;
    send(16'h1234, 16'h0002, 32'h00002468, 1'b0, 1'b1);
    t = 0;
    while (!dst_valid && t < 100) begin
      cyc(1);
      t++;
    end
    chk("hold_dst_valid", {63'h0, dst_valid}, 64'h1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      src_valid = 1'b1;
      src_a = 16'h7777;
      src_b = 16'h1111;
      if (!dst_valid || dst_product !== 32'h00002468 || src_ready || mul_a !== 16'h1234) bad++;
      cyc(1);
    end
    chk("hold_stable_violations", 64'(bad), 64'h0);
    src_valid = 1'b0;
    dst_ready = 1'b1;
    drain();
    cyc(2);
    chk("hold_src_not_stored", {63'h0, mul_start}, 64'h0);
    send(16'h8000, 16'h8000, 32'h40000000, 1'b0, 1'b1);
    drain();

    send(16'd11, 16'd13, 32'h0, 1'b0, 1'b0);
    cyc(5);
    rst = 1'b0;
    cyc(2);
    chk("midrst_dst_valid", {63'h0, dst_valid}, 64'h0);
    rst = 1'b1;
    cyc(1);
    chk("midrst_src_ready", {63'h0, src_ready}, 64'h1);
    chk("midrst_mul_a", {48'h0, mul_a}, 64'h0);
    chk("midrst_mul_b", {48'h0, mul_b}, 64'h0);
    chk("midrst_dst_product", {32'h0, dst_product}, 64'h0);
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (dst_valid || mul_start || dst_err || dst_product !== 32'h0 || !src_ready) bad++;
      cyc(1);
    end
    chk("midrst_late_done_ignored", 64'(bad), 64'h0);

`ifdef MULT_TIMEOUT_EN
    stub_on = 1'b0;
    send(16'd7, 16'd7, 32'h0, 1'b1, 1'b1);
    t = 0;
    while (!dst_valid && t < 100) begin
      cyc(1);
      t++;
    end
    chk("timeout_busy_cycles", 64'(t), 64'd24);
    drain();
    stub_on = 1'b1;
    stub_delay = 24;
    send(16'd2, 16'd3, 32'h00000006, 1'b0, 1'b1);
    drain();
    stub_delay = 17;
`endif

    r0 = results;
    dst_ready = 1'b1;
    src_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src_a = (k == 0) ? 16'd1 : (k == 1) ? 16'hFFFF : 16'd100;
      src_b = (k == 0) ? 16'd1 : (k == 1) ? 16'd2 : 16'd200;
      sb.push_back(exp_t'{p: (k == 0) ? 32'h1 : (k == 1) ? 32'hFFFFFFFE : 32'h00004E20, e: 1'b0});
      wait_ready();
      cyc(1);
    end
    src_valid = 1'b0;
    drain();
    cyc(3);
    chk("b2b_result_count", 64'(results - r0), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
